// File: rtl/chord_mixer_if.sv
// Chord mixer bus: codec request, voice samples/readies in, mixed sample
// and status pulses out. The master side is the sample source (codec
// plus note players); the slave side is the mixer itself.
interface chord_mixer_if;
    logic               generate_next_sample;
    logic [2:0]         voice_active;
    logic signed [15:0] sample_one;
    logic signed [15:0] sample_two;
    logic signed [15:0] sample_three;
    logic               ready_one;
    logic               ready_two;
    logic               ready_three;
    logic signed [15:0] mixed_sample;
    logic               mixed_ready;
    logic               timeout;
    logic               dropped;
    logic [7:0]         clip_count;

    modport master (
        output generate_next_sample, voice_active,
        output sample_one, sample_two, sample_three,
        output ready_one, ready_two, ready_three,
        input  mixed_sample, mixed_ready, timeout, dropped, clip_count
    );

    modport slave (
        input  generate_next_sample, voice_active,
        input  sample_one, sample_two, sample_three,
        input  ready_one, ready_two, ready_three,
        output mixed_sample, mixed_ready, timeout, dropped, clip_count
    );
endinterface

// File: rtl/chord_mixer.sv
// Three-voice chord mixer. A codec request latches the active-voice mask,
// the mixer collects one sample per needed voice (or gives up after
// TIMEOUT_CYCLES), sums them and presents the result with a one-cycle
// mixed_ready pulse.
// Optional feature: define MIXER_SATURATE_EN to clamp the sum to 16 bits
// (counting clips); otherwise the sum is scaled down by 4 and never clips.
module chord_mixer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    chord_mixer_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SUM,
        OUT
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [2:0]         r_needMask;
    logic [2:0]         r_captured;
    logic [CNT_W-1:0]   r_timeoutCount;
    logic               r_timedOut;
    logic signed [15:0] r_sampleOne;
    logic signed [15:0] r_sampleTwo;
    logic signed [15:0] r_sampleThree;
    logic signed [15:0] r_mixedSample;
    logic               r_mixedReady;
    logic               r_timeoutPulse;
    logic               r_dropped;
    logic [7:0]         r_clipCount;

    logic [2:0]         w_readyVec;
    logic [2:0]         w_capturedNext;
    logic               w_allCaptured;
    logic               w_timeoutHit;
    logic signed [17:0] w_contribOne;
    logic signed [17:0] w_contribTwo;
    logic signed [17:0] w_contribThree;
    logic signed [17:0] w_sum;
    logic signed [15:0] w_result;
    logic               w_clip;

    assign w_readyVec     = {bus.ready_three, bus.ready_two, bus.ready_one};
    // Readies seen this cycle count toward completion so the exit is not delayed.
    assign w_capturedNext = r_captured | (w_readyVec & r_needMask);
    assign w_allCaptured  = (w_capturedNext == r_needMask);
    assign w_timeoutHit   = (r_timeoutCount == TIMEOUT_LAST);

    // Uncaptured voices (missing at timeout or not needed) contribute zero.
    assign w_contribOne   = r_captured[0] ? 18'(r_sampleOne)   : 18'sd0;
    assign w_contribTwo   = r_captured[1] ? 18'(r_sampleTwo)   : 18'sd0;
    assign w_contribThree = r_captured[2] ? 18'(r_sampleThree) : 18'sd0;
    assign w_sum          = w_contribOne + w_contribTwo + w_contribThree;

`ifdef MIXER_SATURATE_EN
    // Clamp the wide sum into the 16-bit signed range and flag any clamp.
    always_comb begin
        w_result = w_sum[15:0];
        w_clip   = 1'b0;
        if (w_sum > 18'sd32767) begin
            w_result = 16'sh7FFF;
            w_clip   = 1'b1;
        end else if (w_sum < -18'sd32768) begin
            w_result = 16'sh8000;
            w_clip   = 1'b1;
        end
    end
`else
    logic [1:0] w_unusedBits;

    // Divide by four (arithmetic shift); three 16-bit voices always fit afterwards.
    always_comb begin
        w_result     = w_sum[17:2];
        w_clip       = 1'b0;
        w_unusedBits = w_sum[1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: collect until all needed voices arrive or the counter expires.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.generate_next_sample) w_nextState = COLLECT;
            COLLECT: if (w_allCaptured || w_timeoutHit) w_nextState = SUM;
            SUM:     w_nextState = OUT;
            OUT:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: mask latch, sample capture, timeout count, result and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_needMask     <= 3'b000;
            r_captured     <= 3'b000;
            r_timeoutCount <= '0;
            r_timedOut     <= 1'b0;
            r_sampleOne    <= 16'sd0;
            r_sampleTwo    <= 16'sd0;
            r_sampleThree  <= 16'sd0;
            r_mixedSample  <= 16'sd0;
            r_mixedReady   <= 1'b0;
            r_timeoutPulse <= 1'b0;
            r_dropped      <= 1'b0;
            r_clipCount    <= 8'd0;
        end else begin
            r_mixedReady   <= 1'b0;
            r_timeoutPulse <= 1'b0;
            r_dropped      <= bus.generate_next_sample && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.generate_next_sample) begin
                        r_needMask     <= bus.voice_active;
                        r_captured     <= 3'b000;
                        r_timeoutCount <= '0;
                        r_timedOut     <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (bus.ready_one && r_needMask[0])   r_sampleOne   <= bus.sample_one;
                    if (bus.ready_two && r_needMask[1])   r_sampleTwo   <= bus.sample_two;
                    if (bus.ready_three && r_needMask[2]) r_sampleThree <= bus.sample_three;
                    r_captured <= w_capturedNext;
                    if (!w_allCaptured) begin
                        if (w_timeoutHit) begin
                            r_timedOut <= 1'b1;
                        end else begin
                            r_timeoutCount <= r_timeoutCount + 1'b1;
                        end
                    end
                end
                SUM: begin
                    r_mixedSample  <= w_result;
                    r_mixedReady   <= 1'b1;
                    r_timeoutPulse <= r_timedOut;
                    if (w_clip && (r_clipCount != 8'hFF)) begin
                        r_clipCount <= r_clipCount + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mixed_sample = r_mixedSample;
    assign bus.mixed_ready  = r_mixedReady;
    assign bus.timeout      = r_timeoutPulse;
    assign bus.dropped      = r_dropped;
    assign bus.clip_count   = r_clipCount;

endmodule

// File: tb/tb_chord_mixer.sv
// Directed testbench for chord_mixer. Expected values are hand-computed for
// both builds (with and without MIXER_SATURATE_EN).
module tb_chord_mixer;

    logic clk;
    logic reset;

    chord_mixer_if bus();

    chord_mixer #(.TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MIXER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    int vectorsApplied = 0;
    int miscompares    = 0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic gen, input logic [2:0] mask, input logic [2:0] rdy,
                                 input logic signed [15:0] a, input logic signed [15:0] b,
                                 input logic signed [15:0] c);
        bus.generate_next_sample = gen;
        bus.voice_active         = mask;
        bus.ready_one            = rdy[0];
        bus.ready_two            = rdy[1];
        bus.ready_three          = rdy[2];
        bus.sample_one           = a;
        bus.sample_two           = b;
        bus.sample_three         = c;
    endtask

    task automatic waitMixReady(input int nowCycle, output int readyCycle);
        int cyc  = nowCycle;
        bit seen = bus.mixed_ready;
        while (!seen && (cyc < nowCycle + 200)) begin
            tick();
            cyc++;
            seen = bus.mixed_ready;
        end
        readyCycle = seen ? cyc : -1;
    endtask

    task automatic runSimpleMix(input logic [2:0] mask, input logic signed [15:0] a,
                                input logic signed [15:0] b, input logic signed [15:0] c,
                                output int lat, output int value);
        applyStimulus(1'b1, mask, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, mask, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, mask, mask, a, b, c);
        tick();
        applyStimulus(1'b0, mask, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(3, lat);
        value = $signed(bus.mixed_sample);
        tick();
    endtask

    // Directed scenarios.
    initial begin
        int lat;
        int val;
        int extra;

        reset = 1'b1;
        applyStimulus(1'b0, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        tick();
        checkOutput("reset mixed_sample", $signed(bus.mixed_sample), 0);
        checkOutput("reset mixed_ready", bus.mixed_ready, 0);
        checkOutput("reset timeout", bus.timeout, 0);
        checkOutput("reset dropped", bus.dropped, 0);
        checkOutput("reset clip_count", bus.clip_count, 0);
        reset = 1'b0;
        tick();

        // Basic three-voice mix; mask changed after the request must not matter.
        applyStimulus(1'b1, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b111, 16'sd1000, 16'sd2000, -16'sd500);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(3, lat);
        checkOutput("basic latency", lat, 4);
        checkOutput("basic value", $signed(bus.mixed_sample), SAT_EN ? 2500 : 625);
        checkOutput("basic timeout", bus.timeout, 0);
        tick();
        checkOutput("basic ready pulse width", bus.mixed_ready, 0);
        checkOutput("basic value held", $signed(bus.mixed_sample), SAT_EN ? 2500 : 625);

        // Ready in the request cycle is ignored.
        applyStimulus(1'b1, 3'b001, 3'b001, 16'sd9999, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b001, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b001, 3'b001, 16'sd400, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b001, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(3, lat);
        checkOutput("request-cycle ready latency", lat, 4);
        checkOutput("request-cycle ready value", $signed(bus.mixed_sample), SAT_EN ? 400 : 100);
        tick();

        // Repeat ready overwrites; ready of an unneeded voice is ignored.
        applyStimulus(1'b1, 3'b011, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b011, 3'b101, 16'sd50, 16'sd0, 16'sd4000);
        tick();
        applyStimulus(1'b0, 3'b011, 3'b001, 16'sd80, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b011, 3'b010, 16'sd0, 16'sd40, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b011, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(4, lat);
        checkOutput("overwrite latency", lat, 5);
        checkOutput("overwrite value", $signed(bus.mixed_sample), SAT_EN ? 120 : 30);
        tick();

        // Voice three never arrives: timeout after 64 COLLECT cycles.
        applyStimulus(1'b1, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b111, 3'b011, 16'sd100, 16'sd200, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(2, lat);
        checkOutput("timeout latency", lat, 66);
        checkOutput("timeout flag with ready", bus.timeout, 1);
        checkOutput("timeout value", $signed(bus.mixed_sample), SAT_EN ? 300 : 75);
        tick();
        checkOutput("timeout pulse width", bus.timeout, 0);

        // Empty mask mixes to zero; a request during COLLECT is dropped.
        applyStimulus(1'b1, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b1, 3'b111, 3'b111, 16'sd7, 16'sd7, 16'sd7);
        tick();
        applyStimulus(1'b0, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        checkOutput("dropped pulse", bus.dropped, 1);
        waitMixReady(2, lat);
        checkOutput("empty mask latency", lat, 3);
        checkOutput("empty mask value", $signed(bus.mixed_sample), 0);
        checkOutput("dropped pulse width", bus.dropped, 0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.mixed_ready) extra++;
        end
        checkOutput("no extra mix after drop", extra, 0);

        // Large samples: clamp and count with saturation, scale otherwise.
        runSimpleMix(3'b111, 16'sd20000, 16'sd20000, 16'sd20000, lat, val);
        checkOutput("positive clip latency", lat, 4);
        checkOutput("positive clip value", val, SAT_EN ? 32767 : 15000);
        checkOutput("positive clip count", bus.clip_count, SAT_EN ? 1 : 0);
        runSimpleMix(3'b111, -16'sd20000, -16'sd20000, -16'sd20000, lat, val);
        checkOutput("negative clip value", val, SAT_EN ? -32768 : -15000);
        checkOutput("negative clip count", bus.clip_count, SAT_EN ? 2 : 0);

`ifdef MIXER_SATURATE_EN
        for (int i = 0; i < 253; i++) begin
            runSimpleMix(3'b111, 16'sd20000, 16'sd20000, 16'sd20000, lat, val);
        end
        checkOutput("clip count reaches 255", bus.clip_count, 255);
        runSimpleMix(3'b111, 16'sd20000, 16'sd20000, 16'sd20000, lat, val);
        checkOutput("clip count saturates", bus.clip_count, 255);
`endif

        // Reset during COLLECT aborts the mix; next request mixes fresh samples.
        applyStimulus(1'b1, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b111, 3'b001, 16'sd5000, 16'sd0, 16'sd0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        reset = 1'b0;
        checkOutput("abort mixed_sample", $signed(bus.mixed_sample), 0);
        checkOutput("abort mixed_ready", bus.mixed_ready, 0);
        checkOutput("abort timeout", bus.timeout, 0);
        checkOutput("abort clip_count", bus.clip_count, 0);
        applyStimulus(1'b1, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        checkOutput("post-abort request accepted", bus.dropped, 0);
        applyStimulus(1'b0, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        tick();
        applyStimulus(1'b0, 3'b111, 3'b111, 16'sd300, 16'sd400, 16'sd500);
        tick();
        applyStimulus(1'b0, 3'b111, 3'b000, 16'sd0, 16'sd0, 16'sd0);
        waitMixReady(6, lat);
        checkOutput("post-abort latency", lat, 7);
        checkOutput("post-abort value", $signed(bus.mixed_sample), SAT_EN ? 1200 : 300);
        checkOutput("post-abort timeout", bus.timeout, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/chord_mixer.md
CHORD_MIXER -- requirements
Module: chord_mixer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum COLLECT cycles before missing voices are forced to zero.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 generate_next_sample  input  1  codec request pulse for one mixed sample.
REQ-005 voice_active  input  3  per-voice enable mask; bit0 = voice one.
REQ-006 sample_one, sample_two, sample_three  input  16 each  signed two's-complement note_player samples.
REQ-007 ready_one, ready_two, ready_three  input  1 each  per-voice sample-valid pulses.
REQ-008 mixed_sample  output  16  signed mixed sample; held between updates.
REQ-009 mixed_ready  output  1  one-cycle pulse when mixed_sample updates; drives the codec conditioner's latch input.
REQ-010 timeout  output  1  one-cycle pulse, coincident with mixed_ready, when a mix closed by timeout.
REQ-011 dropped  output  1  one-cycle pulse when a request arrives outside IDLE.
REQ-012 clip_count  output  8  saturating count of clipped mixes.

Function
REQ-013 FSM states SHALL be IDLE, COLLECT, SUM and OUT.
REQ-014 IDLE: on generate_next_sample, latch voice_active as need mask, clear captured flags and timeout counter, go to COLLECT.
REQ-015 Ready pulses in the request cycle SHALL be ignored.
REQ-016 COLLECT: on ready_x with need bit x set, capture sample_x and set captured flag x; ready for unneeded voices is ignored; a repeat ready overwrites the capture.
REQ-017 COLLECT exits to SUM on the edge where every needed voice is captured, counting readies sampled that same cycle.
REQ-018 Need mask 3'b000 SHALL exit COLLECT after one cycle with all contributions zero.
REQ-019 Timeout counter increments each COLLECT cycle; at TIMEOUT_CYCLES-1 go to SUM, uncaptured voices contribute 0, and flag timeout.
REQ-020 SUM: form 18-bit sign-extended sum of the three contributions, produce result per REQ-027/028, and go to OUT.
REQ-021 OUT: mixed_sample register updated, mixed_ready high one cycle, timeout pulsed if flagged, return to IDLE.
REQ-022 Latency: mixed_ready SHALL assert exactly 2 cycles after the cycle in which the last needed ready is sampled.
REQ-023 generate_next_sample outside IDLE SHALL be ignored and pulse dropped the next cycle.
REQ-024 voice_active changes after the request SHALL have no effect on the current mix.
REQ-025 clip_count increments on each clipped mix and saturates at 255 without wrapping.

Reset
REQ-026 Reset SHALL force IDLE, mixed_sample=0, mixed_ready=0, timeout=0, dropped=0, clip_count=0, and clear captured flags, mask and counter, aborting any mix in progress.

Configuration
REQ-027 With MIXER_SATURATE_EN defined: result = 18-bit sum clamped to [-32768, 32767]; a clamp counts as a clip.
REQ-028 Without MIXER_SATURATE_EN: result = sum arithmetically shifted right by 2, never clips, and clip_count stays 0.

Verification
REQ-029 Mask 111, request at cycle 0, samples 1000/2000/-500 all ready at cycle 2 -> mixed_ready at cycle 4 with 2500 (saturate) or 625 (shift).
REQ-030 With saturation, samples 20000 x3 -> 32767 and clip_count=1; samples -20000 x3 -> -32768 and clip_count=2.
REQ-031 Mask 111, ready_three never asserted, samples 100/200 -> after 64 COLLECT cycles mixed_sample=300 with timeout and mixed_ready pulsing together.
REQ-032 Mask 000 -> mixed_ready at cycle 3 with mixed_sample=0; a second request during COLLECT -> dropped pulse, no extra mix.
REQ-033 Reset asserted in COLLECT after one capture -> IDLE and outputs zero; next request with all voices ready -> a correct fresh mix, with no stale capture used.
